// File: rtl/host_uart_pkg.sv
// host_uart_pkg
// Shared definitions for the host UART bridge: the common RX/TX state type,
// the UART frame shape and the clock-divider helper.
package host_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per UART bit; callers guarantee an exact, >= 4 result.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/host_sync_fifo.sv
// host_sync_fifo
// Single-clock FIFO with registered pop data, registered empty/full flags,
// and simultaneous push/pop (push accepted when full if a pop also occurs;
// a pop while empty is ignored even if a push arrives in the same cycle).
//
// Ports:
//   CLK, RESET    clock, asynchronous active-high reset
//   i_push        write strobe; i_push_data is the byte written
//   i_pop         read strobe; o_pop_data updates on that edge
//   o_empty       registered empty flag
//   o_full        registered full flag
module host_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_empty;
  logic             r_full;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CW-1:0]    w_count_nxt;

  // When full, a concurrent pop frees the slot the push lands in.
  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pop_data <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_pop_data <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign o_pop_data = r_pop_data;
  assign o_empty    = r_empty;
  assign o_full     = r_full;

endmodule

// File: rtl/host_uart_bridge.sv
// host_uart_bridge
// Transparent UART <-> byte FIFO bridge feeding the AHB3 host master.
// RX: 2-flop synchronizer, mid-bit sampling deserializer, RX FIFO.
// TX: TX FIFO, serializer producing back-to-back 10-bit frames.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   UART_RX, UART_TX  serial link to host (UART_TX idles high, flop driven)
//   RDEN/RDEMPTY/RDDATA   RX FIFO read side (RDDATA valid cycle after RDEN)
//   WREN/WRFULL/WRDATA    TX FIFO write side (writes when full are dropped)
//   OVERRUN           sticky: received byte lost to a full RX FIFO
//   FRAMERR           sticky: received stop bit sampled low
//
// state | meaning (RX / TX)
// IDLE  | RX waits for line low / TX waits for a queued byte
// START | RX times to mid start bit / TX drives the start bit
// DATA  | eight data bits, LSB first
// STOP  | RX checks stop bit, holds on error until line high / TX stop bit
module host_uart_bridge
  import host_uart_pkg::*;
#(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 3000000,
  parameter int DEPTH    = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic       UART_TX,
  input  logic       RDEN,
  output logic       RDEMPTY,
  output logic [7:0] RDDATA,
  input  logic       WREN,
  output logic       WRFULL,
  input  logic [7:0] WRDATA,
  output logic       OVERRUN,
  output logic       FRAMERR
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // RX synchronizer and deserializer
  logic              r_rx_meta;
  logic              r_rx_sync;
  uart_state_t       r_rx_state;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [BIT_W-1:0]  r_rx_bitn;
  logic [7:0]        r_rx_shift;
  logic              r_rx_drop;
  logic              r_rx_push;
  logic              r_framerr;
  logic              r_overrun;
  logic              w_rx_full;

  // TX serializer
  uart_state_t       r_tx_state;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [BIT_W-1:0]  r_tx_bitn;
  logic [7:0]        r_tx_shift;
  logic              r_uart_tx;
  logic              w_tx_pop;
  logic              w_tx_empty;
  logic [7:0]        w_tx_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bitn  <= '0;
      r_rx_shift <= '0;
      r_rx_drop  <= 1'b0;
      r_rx_push  <= 1'b0;
      r_framerr  <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_state)
        IDLE: begin
          if (!r_rx_sync) begin
            r_rx_cnt   <= CNT_HALF;
            r_rx_state <= START;
          end
        end
        START: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else if (r_rx_sync) begin
            r_rx_state <= IDLE;
          end else begin
            r_rx_cnt   <= CNT_FULL;
            r_rx_bitn  <= '0;
            r_rx_state <= DATA;
          end
        end
        DATA: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_cnt   <= CNT_FULL;
            if (r_rx_bitn == BIT_LAST) begin
              r_rx_state <= STOP;
            end else begin
              r_rx_bitn <= r_rx_bitn + 1'b1;
            end
          end
        end
        STOP: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else if (r_rx_drop) begin
            // Bad stop bit: hold here so a low line is not mistaken for a new start.
            if (r_rx_sync) begin
              r_rx_drop  <= 1'b0;
              r_rx_state <= IDLE;
            end
          end else if (r_rx_sync) begin
            r_rx_push  <= 1'b1;
            r_rx_state <= IDLE;
          end else begin
            r_framerr <= 1'b1;
            r_rx_drop <= 1'b1;
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end

  // A full FIFO only accepts the push if the master pops in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_overrun <= 1'b0;
    end else if (r_rx_push && w_rx_full && !RDEN) begin
      r_overrun <= 1'b1;
    end
  end

  host_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (r_rx_push),
    .i_push_data (r_rx_shift),
    .i_pop       (RDEN),
    .o_pop_data  (RDDATA),
    .o_empty     (RDEMPTY),
    .o_full      (w_rx_full)
  );

  host_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (WREN),
    .i_push_data (WRDATA),
    .i_pop       (w_tx_pop),
    .o_pop_data  (w_tx_data),
    .o_empty     (w_tx_empty),
    .o_full      (WRFULL)
  );

  // Pop at idle or on the last stop-bit cycle so frames run back to back.
  // The popped byte is registered and is consumed at the end of the start bit.
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == IDLE) ||
                     ((r_tx_state == STOP) && (r_tx_cnt == '0) && (r_tx_bitn == STOP_LAST)));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_shift <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (w_tx_pop) begin
            r_uart_tx  <= 1'b0;
            r_tx_cnt   <= CNT_FULL;
            r_tx_state <= START;
          end
        end
        START: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_uart_tx  <= w_tx_data[0];
            r_tx_shift <= {1'b1, w_tx_data[7:1]};
            r_tx_cnt   <= CNT_FULL;
            r_tx_bitn  <= '0;
            r_tx_state <= DATA;
          end
        end
        DATA: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_tx_cnt <= CNT_FULL;
            if (r_tx_bitn == BIT_LAST) begin
              r_uart_tx  <= 1'b1;
              r_tx_bitn  <= '0;
              r_tx_state <= STOP;
            end else begin
              r_uart_tx  <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[7:1]};
              r_tx_bitn  <= r_tx_bitn + 1'b1;
            end
          end
        end
        STOP: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else if (r_tx_bitn != STOP_LAST) begin
            r_tx_bitn <= r_tx_bitn + 1'b1;
            r_tx_cnt  <= CNT_FULL;
          end else if (w_tx_pop) begin
            r_uart_tx  <= 1'b0;
            r_tx_cnt   <= CNT_FULL;
            r_tx_state <= START;
          end else begin
            r_tx_state <= IDLE;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  assign UART_TX = r_uart_tx;
  assign OVERRUN = r_overrun;
  assign FRAMERR = r_framerr;

endmodule

// File: tb/tb_host_uart_bridge.sv
module tb_host_uart_bridge;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       UART_RX;
  logic       UART_TX;
  logic       RDEN;
  logic       RDEMPTY;
  logic [7:0] RDDATA;
  logic       WREN;
  logic       WRFULL;
  logic [7:0] WRDATA;
  logic       OVERRUN;
  logic       FRAMERR;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ftick;
  int fall;
  logic tx_log [0:32767];

  host_uart_bridge #(
    .CLK_FREQ (48000000),
    .BAUD     (3000000),
    .DEPTH    (16)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .UART_RX (UART_RX),
    .UART_TX (UART_TX),
    .RDEN    (RDEN),
    .RDEMPTY (RDEMPTY),
    .RDDATA  (RDDATA),
    .WREN    (WREN),
    .WRFULL  (WRFULL),
    .WRDATA  (WRDATA),
    .OVERRUN (OVERRUN),
    .FRAMERR (FRAMERR)
  );

  always #5 CLK = ~CLK;

  // Line recorder: tx_log[k] is UART_TX at the negedge where cyc == k.
  always @(negedge CLK) begin
    tx_log[cyc[14:0]] <= UART_TX;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic rx_tick();
    @(negedge CLK);
    ftick++;
    if (fall < 0 && RDEMPTY === 1'b0) fall = ftick;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    ftick = 0;
    fall  = -1;
    UART_RX = 1'b0;
    repeat (DIV) rx_tick();
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (DIV) rx_tick();
    end
    UART_RX = stop_bit;
    repeat (DIV) rx_tick();
    UART_RX = 1'b1;
  endtask

  function automatic int find_start(input int from, input int lim);
    for (int i = from; i < from + lim; i++) begin
      if (tx_log[i[14:0]] === 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] decode(input int s, input int f);
    logic [7:0] b;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx  = s + f * FRAME + DIV + k * DIV + DIV / 2;
      b[k] = tx_log[idx[14:0]];
    end
    return b;
  endfunction

  function automatic int count_ones(input int from, input int n);
    int c = 0;
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = from + i;
      if (tx_log[idx[14:0]] === 1'b1) c++;
    end
    return c;
  endfunction

  logic [7:0] burst [3] = '{8'h00, 8'hFF, 8'h3C};

  initial begin
    int mark;
    int s;
    int nm;
    int idx;
    logic exp_bit;

    RESET = 1'b1; UART_RX = 1'b1; RDEN = 1'b0; WREN = 1'b0; WRDATA = 8'h00;
    ticks(3);
    chk("rst_uart_tx", 32'(UART_TX), 32'd1);
    chk("rst_rdempty", 32'(RDEMPTY), 32'd1);
    chk("rst_wrfull",  32'(WRFULL),  32'd0);
    chk("rst_rddata",  32'(RDDATA),  32'h00);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    chk("rst_framerr", 32'(FRAMERR), 32'd0);
    RESET = 1'b0;
    ticks(2);

    // RX 0xA5 with latency bound, single pop, pop-while-empty hold
    send_byte(8'hA5, 1'b1);
    chk("rx_a5_latency_le156", 32'((fall > 0) && (fall <= 2 + 16 * 19 / 2 + 2)), 32'd1);
    RDEN = 1'b1; ticks(1); RDEN = 1'b0;
    chk("rx_a5_rddata",  32'(RDDATA),  32'hA5);
    chk("rx_a5_rdempty", 32'(RDEMPTY), 32'd1);
    RDEN = 1'b1; ticks(1); RDEN = 1'b0;
    chk("rx_pop_empty_hold", 32'(RDDATA), 32'hA5);

    // TX burst: three back-to-back frames of exactly FRAME cycles
    mark = cyc;
    WREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WRDATA = burst[i];
      ticks(1);
    end
    WREN = 1'b0;
    ticks(3 * FRAME + 40);
    s = find_start(mark, 20);
    chk("tx_burst_start_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = mark;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 10; b++) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : burst[f][b-1];
        nm = 0;
        for (int c = 0; c < DIV; c++) begin
          idx = s + f * FRAME + b * DIV + c;
          if (tx_log[idx[14:0]] === exp_bit) nm++;
        end
        chk($sformatf("tx_burst_f%0d_bit%0d_samples", f, b), 32'(nm), 32'd16);
      end
    end
    chk("tx_burst_idle_after", 32'(count_ones(s + 3 * FRAME, 30)), 32'd30);

    // 4-cycle glitch on RX: no byte, no flags
    UART_RX = 1'b0; ticks(4); UART_RX = 1'b1;
    ticks(200);
    chk("glitch_rdempty", 32'(RDEMPTY), 32'd1);
    chk("glitch_framerr", 32'(FRAMERR), 32'd0);
    chk("glitch_overrun", 32'(OVERRUN), 32'd0);

    // Fill TX FIFO (one byte already popped by the serializer), then write while full
    mark = cyc;
    WREN = 1'b1;
    for (int i = 0; i < 17; i++) begin
      WRDATA = 8'h40 + 8'(i);
      ticks(1);
    end
    WREN = 1'b0;
    chk("tx_wrfull_after_17", 32'(WRFULL), 32'd1);
    WREN = 1'b1; WRDATA = 8'hEE; ticks(1); WREN = 1'b0;
    chk("tx_wrfull_after_drop", 32'(WRFULL), 32'd1);
    ticks(17 * FRAME + 60);
    s = find_start(mark, 20);
    chk("tx_fill_start_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = mark;
    for (int f = 0; f < 17; f++) begin
      chk($sformatf("tx_fill_byte%0d", f), 32'(decode(s, f)), 32'(8'h40 + 8'(f)));
    end
    chk("tx_no_ee_frame", 32'(count_ones(s + 17 * FRAME, 40)), 32'd40);
    chk("tx_wrfull_drained", 32'(WRFULL), 32'd0);

    // Framing error then a valid byte
    send_byte(8'h55, 1'b0);
    ticks(30);
    chk("ferr_framerr", 32'(FRAMERR), 32'd1);
    chk("ferr_no_push", 32'(RDEMPTY), 32'd1);
    send_byte(8'h66, 1'b1);
    ticks(10);
    chk("ferr_next_rdempty", 32'(RDEMPTY), 32'd0);
    RDEN = 1'b1; ticks(1); RDEN = 1'b0;
    chk("ferr_next_rddata", 32'(RDDATA), 32'h66);
    chk("ferr_overrun_clear", 32'(OVERRUN), 32'd0);

    // RX overflow: DEPTH+2 bytes without reading
    for (int i = 1; i <= 18; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 16) begin
        ticks(2);
        chk("ovf_none_at_depth", 32'(OVERRUN), 32'd0);
      end
    end
    ticks(5);
    chk("ovf_overrun", 32'(OVERRUN), 32'd1);
    RDEN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ticks(1);
      chk($sformatf("ovf_read%0d", i), 32'(RDDATA), 32'(i));
    end
    RDEN = 1'b0;
    chk("ovf_empty_after_reads", 32'(RDEMPTY), 32'd1);
    RDEN = 1'b1; ticks(1); RDEN = 1'b0;
    chk("ovf_pop_empty_hold", 32'(RDDATA), 32'h10);

    // Reset during TX data bits, with both FIFOs holding data
    send_byte(8'h77, 1'b1);
    ticks(5);
    chk("pre_rst_rx_nonempty", 32'(RDEMPTY), 32'd0);
    WREN = 1'b1;
    WRDATA = 8'h81; ticks(1);
    WRDATA = 8'h22; ticks(1);
    WRDATA = 8'h33; ticks(1);
    WREN = 1'b0;
    ticks(40);
    chk("pre_rst_tx_low", 32'(UART_TX), 32'd0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_uart_tx", 32'(UART_TX), 32'd1);
    chk("rst_mid_rdempty", 32'(RDEMPTY), 32'd1);
    chk("rst_mid_wrfull",  32'(WRFULL),  32'd0);
    chk("rst_mid_overrun", 32'(OVERRUN), 32'd0);
    chk("rst_mid_framerr", 32'(FRAMERR), 32'd0);
    ticks(3);
    RESET = 1'b0;
    mark = cyc;
    ticks(200);
    chk("post_rst_tx_idle", 32'(count_ones(mark, 190)), 32'd190);
    chk("post_rst_rdempty", 32'(RDEMPTY), 32'd1);
    mark = cyc;
    WREN = 1'b1; WRDATA = 8'h5A; ticks(1); WREN = 1'b0;
    ticks(FRAME + 40);
    s = find_start(mark, 20);
    chk("post_rst_start_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = mark;
    chk("post_rst_byte", 32'(decode(s, 0)), 32'h5A);
    chk("post_rst_stop", 32'(count_ones(s + 9 * DIV, DIV)), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
